// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: ID-stage beq/bne hazard stalls, operand forwarding, resolve and statistics.
module branch_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beq_ID,
  input  logic             bne_ID,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       rd_EX,
  input  logic             RegWrite_MEM,
  input  logic             MemRead_MEM,
  input  logic [4:0]       rd_MEM,
  input  logic             Zero1,
  output logic             AluctrlB,
  output logic             ForwardA1,
  output logic             ForwardB1,
  output logic             stall,
  output logic             PCSrc,
  output logic             flush_IFID,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, taken_cnt_q, taken_cnt_d;
  logic             br, resolve, fwd_a, fwd_b;
  logic             ex_a, ex_b, mem_a, mem_b;
  logic [1:0]       need_a, need_b, need;

  assign br     = beq_ID | bne_ID;
  assign ex_a   = RegWrite_EX && rd_EX != 5'd0 && rd_EX == rs_ID;
  assign ex_b   = RegWrite_EX && rd_EX != 5'd0 && rd_EX == rt_ID;
  assign mem_a  = RegWrite_MEM && MemRead_MEM && rd_MEM != 5'd0 && rd_MEM == rs_ID;
  assign mem_b  = RegWrite_MEM && MemRead_MEM && rd_MEM != 5'd0 && rd_MEM == rt_ID;
  assign need_a = rs_ID == 5'd0 ? 2'd0 : ex_a ? (MemRead_EX ? 2'd2 : 2'd1) : mem_a ? 2'd1 : 2'd0;
  assign need_b = rt_ID == 5'd0 ? 2'd0 : ex_b ? (MemRead_EX ? 2'd2 : 2'd1) : mem_b ? 2'd1 : 2'd0;
  assign need   = need_a > need_b ? need_a : need_b;
  assign fwd_a  = RegWrite_MEM && !MemRead_MEM && rd_MEM != 5'd0 && rd_MEM == rs_ID;
  assign fwd_b  = RegWrite_MEM && !MemRead_MEM && rd_MEM != 5'd0 && rd_MEM == rt_ID;
  assign resolve = rst_n && ((state_q == IDLE && br && need == 2'd0) ||
                             (state_q == STALL && cnt_q == 2'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      mode_q       <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (state_q == IDLE && br) begin
      mode_d = beq_ID;
      if (need != 2'd0) begin
        state_d = STALL;
        cnt_d   = 2'(need - 2'd1);
      end
    end else if (state_q == STALL) begin
      cnt_d   = cnt_q != 2'd0 ? 2'(cnt_q - 2'd1) : cnt_q;
      state_d = cnt_q != 2'd0 ? STALL : IDLE;
    end
    // Counters saturate at all-ones rather than wrapping.
    if (resolve) begin
      branch_cnt_d = &branch_cnt_q ? branch_cnt_q : branch_cnt_q + CNT_W'(1);
      taken_cnt_d  = (&taken_cnt_q || !Zero1) ? taken_cnt_q : taken_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    AluctrlB   = rst_n && (state_q == STALL ? mode_q : beq_ID);
    stall      = rst_n && ((state_q == IDLE && br && need != 2'd0) ||
                           (state_q == STALL && cnt_q != 2'd0));
    PCSrc      = resolve && Zero1;
    flush_IFID = resolve && Zero1;
    ForwardA1  = resolve && fwd_a;
    ForwardB1  = resolve && fwd_b;
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed vectors for branch_hazard_ctrl with hand-computed expectations.
module tb_branch_hazard_ctrl;
  logic clk = 1'b0, rst_n;
  logic beq_ID, bne_ID, RegWrite_EX, MemRead_EX, RegWrite_MEM, MemRead_MEM, Zero1;
  logic [4:0] rs_ID, rt_ID, rd_EX, rd_MEM;
  logic AluctrlB, ForwardA1, ForwardB1, stall, PCSrc, flush_IFID;
  logic [15:0] branch_cnt, taken_cnt;
  logic s_AluctrlB, s_ForwardA1, s_ForwardB1, s_stall, s_PCSrc, s_flush_IFID;
  logic [1:0] s_branch_cnt, s_taken_cnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .beq_ID(beq_ID), .bne_ID(bne_ID), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .rd_EX(rd_EX),
    .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM), .rd_MEM(rd_MEM), .Zero1(Zero1),
    .AluctrlB(AluctrlB), .ForwardA1(ForwardA1), .ForwardB1(ForwardB1), .stall(stall),
    .PCSrc(PCSrc), .flush_IFID(flush_IFID), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  // Narrow-counter copy sharing all inputs, so saturation is reachable in a few branches.
  branch_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .beq_ID(beq_ID), .bne_ID(bne_ID), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .rd_EX(rd_EX),
    .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM), .rd_MEM(rd_MEM), .Zero1(Zero1),
    .AluctrlB(s_AluctrlB), .ForwardA1(s_ForwardA1), .ForwardB1(s_ForwardB1), .stall(s_stall),
    .PCSrc(s_PCSrc), .flush_IFID(s_flush_IFID), .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    beq_ID = 0; bne_ID = 0; rs_ID = 0; rt_ID = 0; Zero1 = 0;
    RegWrite_EX = 0; MemRead_EX = 0; rd_EX = 0;
    RegWrite_MEM = 0; MemRead_MEM = 0; rd_MEM = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [5:0] exp);
    check(tag, {AluctrlB, ForwardA1, ForwardB1, stall, PCSrc, flush_IFID}, exp);
  endtask

  initial begin
    clear_in();
    rst_n = 0; beq_ID = 1; Zero1 = 1;
    repeat (3) tick();
    // Output vector order: AluctrlB, ForwardA1, ForwardB1, stall, PCSrc, flush_IFID
    check_outs("rst_outs", 6'b000000);
    check("rst_bcnt", branch_cnt, 0);
    check("rst_tcnt", taken_cnt, 0);

    rst_n = 1; beq_ID = 1; rs_ID = 3; rt_ID = 4; Zero1 = 1;
    #1 check_outs("nohz_resolve", 6'b100011);
    tick(); clear_in();
    #1 check_outs("nohz_after", 6'b000000);
    check("nohz_bcnt", branch_cnt, 1);
    check("nohz_tcnt", taken_cnt, 1);

    bne_ID = 1; rs_ID = 5; rt_ID = 6; RegWrite_EX = 1; rd_EX = 5;
    #1 check_outs("alu_c0", 6'b000100);
    tick();
    RegWrite_EX = 0; rd_EX = 0; RegWrite_MEM = 1; rd_MEM = 5;
    #1 check_outs("alu_c1", 6'b010000);
    tick(); clear_in();
    #1 check("alu_bcnt", branch_cnt, 2);
    check("alu_tcnt", taken_cnt, 1);

    beq_ID = 1; rs_ID = 1; rt_ID = 7; RegWrite_EX = 1; MemRead_EX = 1; rd_EX = 7; Zero1 = 1;
    #1 check_outs("ld_c0", 6'b100100);
    tick();
    RegWrite_EX = 0; MemRead_EX = 0; rd_EX = 0; RegWrite_MEM = 1; MemRead_MEM = 1; rd_MEM = 7;
    #1 check_outs("ld_c1", 6'b100100);
    tick();
    RegWrite_MEM = 0; MemRead_MEM = 0; rd_MEM = 0;
    #1 check_outs("ld_c2", 6'b100011);
    tick(); clear_in();
    #1 check_outs("ld_after", 6'b000000);
    check("ld_bcnt", branch_cnt, 3);
    check("ld_tcnt", taken_cnt, 2);

    beq_ID = 1; RegWrite_EX = 1; rd_EX = 0; RegWrite_MEM = 1; rd_MEM = 0;
    #1 check_outs("r0", 6'b100000);
    tick(); clear_in();
    #1 check("r0_bcnt", branch_cnt, 4);

    bne_ID = 1; rs_ID = 9; rt_ID = 2; RegWrite_MEM = 1; MemRead_MEM = 1; rd_MEM = 9; Zero1 = 1;
    #1 check_outs("memld_c0", 6'b000100);
    tick();
    RegWrite_MEM = 0; MemRead_MEM = 0; rd_MEM = 0;
    #1 check_outs("memld_c1", 6'b000011);
    tick(); clear_in();
    #1 check("memld_tcnt", taken_cnt, 3);

    beq_ID = 1; rt_ID = 7; RegWrite_EX = 1; MemRead_EX = 1; rd_EX = 7; Zero1 = 1;
    #1 check_outs("mid_c0", 6'b100100);
    rst_n = 0;
    #1 check_outs("mid_rst_comb", 6'b000000);
    tick(); rst_n = 1; clear_in();
    #1 check("mid_stall", stall, 0);
    check("mid_bcnt", branch_cnt, 0);
    check("mid_tcnt", taken_cnt, 0);
    check("mid_sat_bcnt", s_branch_cnt, 0);

    beq_ID = 1; rs_ID = 3; rt_ID = 4; Zero1 = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("sat_bcnt", branch_cnt, i);
      check("sat_small_bcnt", s_branch_cnt, i > 3 ? 3 : i);
      check("sat_small_tcnt", s_taken_cnt, i > 3 ? 3 : i);
    end
    clear_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Controls the ID-stage branch comparator/target adder for beq/bne in the 5-stage pipeline.
- Detects data hazards on the comparator operands and sequences 0–2 stall cycles.
- Drives forwarding selects and the comparator mode, then on resolution drives PC source select and IF/ID flush.
- Keeps saturating branch and taken-branch statistics counters.

Parameters:
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- beq_ID  input  1  beq decoded in ID.
- bne_ID  input  1  bne decoded in ID.
- rs_ID  input  5  source register A of the branch in ID.
- rt_ID  input  5  source register B of the branch in ID.
- RegWrite_EX  input  1  instruction in EX writes a register.
- MemRead_EX  input  1  instruction in EX is a load.
- rd_EX  input  5  destination register of the instruction in EX.
- RegWrite_MEM  input  1  instruction in MEM writes a register.
- MemRead_MEM  input  1  instruction in MEM is a load.
- rd_MEM  input  5  destination register of the instruction in MEM.
- Zero1  input  1  comparator result; 1 = branch condition met, for either mode.
- AluctrlB  output  1  comparator mode: 1 = beq, 0 = bne.
- ForwardA1  output  1  1 = operand A taken from the EX/MEM ALU result; 0 = register file.
- ForwardB1  output  1  1 = operand B taken from the EX/MEM ALU result; 0 = register file.
- stall  output  1  hold PC and IF/ID, and insert a bubble into ID/EX.
- PCSrc  output  1  1 = load PC with the branch target PC_ID.
- flush_IFID  output  1  squash the instruction in IF/ID.
- branch_cnt  output  CNT_W  resolved branches.
- taken_cnt  output  CNT_W  taken branches.

Behaviour:
- Reset (rst_n=0 at a clock edge): state goes to IDLE, stall counter to 0, mode register to 0, branch_cnt and taken_cnt to 0. While rst_n=0, all combinational outputs are forced to 0.
- br = beq_ID | bne_ID. If both are asserted, beq has priority.
- Operand hazard, evaluated per operand r (rs_ID, rt_ID) only when r != 0:
  - EX match = RegWrite_EX & rd_EX!=0 & rd_EX==r. A match with MemRead_EX needs 2 stalls; a match without it needs 1.
  - Otherwise, MEM match = RegWrite_MEM & MemRead_MEM & rd_MEM!=0 & rd_MEM==r. This needs 1 stall.
  - Otherwise 0 stalls.
  - need = maximum over both operands.
- States: IDLE and STALL. The internal counter cnt is 2 bits.
- IDLE with br=1:
  - mode register <= beq_ID.
  - need=0: resolve this cycle (see Resolve); stay in IDLE.
  - need>0: stall=1, cnt <= need-1, go to STALL. PCSrc and flush_IFID are 0; counters are unchanged.
- IDLE with br=0: all outputs 0 except AluctrlB, which follows beq_ID combinationally.
- STALL:
  - cnt!=0: stall=1, cnt <= cnt-1.
  - cnt==0: stall=0, resolve, go to IDLE.
  - br and rs/rt are held stable by the stall. The hazard is not re-evaluated in STALL.
- AluctrlB equals beq_ID in IDLE and the mode register in STALL.
- Forwarding, combinational, valid in the resolve cycle:
  - ForwardA1 = RegWrite_MEM & !MemRead_MEM & rd_MEM!=0 & rd_MEM==rs_ID.
  - ForwardB1 is the same with rt_ID.
  - Both are 0 in stall cycles.
  - WB-stage values reach the comparator through the register file's write-before-read; no WB forward is provided.
- Resolve cycle:
  - PCSrc = Zero1 and flush_IFID = Zero1, each for exactly one cycle.
  - branch_cnt += 1; taken_cnt += Zero1.
  - Both counters saturate at all-ones.
- Latency, measured from the cycle the branch first appears in ID:
  - no hazard: resolve in the same cycle;
  - 1-stall hazard: resolve one cycle later;
  - 2-stall hazard (load in EX): resolve two cycles later.
- Back-to-back branches: a branch entering ID the cycle after a not-taken resolve is handled as a fresh IDLE entry.
- Reset mid-stall: at the next edge the state returns to IDLE and stall drops. No resolve occurs and the counters clear.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with beq_ID=1 and Zero1=1 → every output 0, branch_cnt=0, taken_cnt=0.
- Hazard-free beq, rs=3, rt=4, no EX/MEM matches, Zero1=1 → same cycle: AluctrlB=1, PCSrc=1, flush_IFID=1, stall=0; branch_cnt=1, taken_cnt=1.
- bne, rs=5, with EX = ALU op writing r5 (RegWrite_EX=1, MemRead_EX=0), Zero1=0 in the resolve cycle:
  - cycle 0: stall=1;
  - cycle 1: stall=0, ForwardA1=1, PCSrc=0, AluctrlB=0;
  - branch_cnt increments, taken_cnt unchanged.
- beq, rt=7, with a load in EX writing r7:
  - cycles 0 and 1: stall=1;
  - cycle 2: resolve with ForwardB1=0; Zero1=1 gives PCSrc=1.
- Register $0: beq with rs=0, rt=0 while EX writes rd=0 → need=0, no stall, no forwarding.
- Reset mid-stall and saturation:
  - load-use hazard, rst_n=0 in stall cycle 0 → stall=0 after the edge, counters 0;
  - separately, preload the counters to 0xFFFF and resolve a taken branch → both counters stay at 0xFFFF.
